demux4_hold: RTL and testbench
==============================

Name: demux4_hold

Overview:
- 4-way registered demultiplexer with valid/ready handshakes on every side; the write-direction counterpart of the 4:1 operand mux.
- Accepts one WIDTH-bit word per transfer on a single input channel and routes it by a 2-bit select into one of four single-entry holding registers.
- Each register drains independently to its own consumer, e.g. multicycle datapath results routed to the register file, memory data register, PC or ALU-out latch.

Parameters:
WIDTH, 32, data width of input word and of each output channel

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all held words
in_valid  input  1  producer presents a word
in_ready  output  1  block can accept the word on in_sel this cycle
in_sel  input  2  destination channel index 0..3
in_data  input  WIDTH  word to route
out_valid  output  4  bit k: channel k holds a valid word
out_ready  input  4  bit k: consumer k takes the word this cycle
out_data0  output  WIDTH  channel 0 held word
out_data1  output  WIDTH  channel 1 held word
out_data2  output  WIDTH  channel 2 held word
out_data3  output  WIDTH  channel 3 held word
busy  output  1  OR of out_valid

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n), asserted at any time.
  - Immediately forces out_valid=4'b0000, out_data0..3=0 and busy=0.
  - in_ready follows combinationally as 1 once flush=0.
  - A transfer in flight when reset asserts is dropped; there is no partial state.
- Per-channel state: holding register data_k and valid bit v_k. Channel k is either EMPTY (v_k=0) or FULL (v_k=1).
- Acceptance:
  - in_ready = ~flush & (~v[in_sel] | out_ready[in_sel]).
  - in_ready is combinational from in_sel, registered v and out_ready. It is independent of in_valid; there is no combinational path from in_valid to in_ready.
  - Accept = in_valid & in_ready.
- Load: on accept, at the next edge data_{in_sel} <= in_data and v_{in_sel} <= 1. Latency is exactly 1 cycle from accept to out_valid.
- Drain:
  - Channel k transfers when v_k & out_ready[k].
  - At the next edge v_k <= 0, unless the same channel is reloaded by an accept in that cycle. Then v_k stays 1 and data_k takes the new word (pass-through, full throughput).
- Independence: all four channels drain concurrently in the same cycle. An accept to channel j never disturbs channel k≠j.
- Stability: while v_k=1 and out_ready[k]=0, data_k and v_k hold unchanged. The producer is back-pressured only when its selected channel is blocked, never by other channels.
- Empty channel: data_k holds its last value after draining, or 0 after reset. Consumers must ignore data when v_k=0.
- out_ready[k] while v_k=0 has no effect.
- Flush:
  - Flush=1 forces in_ready=0, so no accept.
  - At the next edge all v_k <= 0, overriding any reload; data registers are unchanged.
  - Drains handshaked during the flush cycle still count as completed.
- busy = |out_valid, combinational from registers.
- in_sel and in_data are don't-care when in_valid=0. No X propagation into state when in_valid=0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with v=4'b0101 -> out_valid=0 and out_data0..3=0 immediately, busy=0. Release with flush=0 -> in_ready=1 for every in_sel.
- Routing: send in_sel=0..3 with data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, out_ready=0 -> one cycle after each accept the matching out_valid bit is set. Final out_valid=4'b1111 with each out_dataK holding its word.
- Backpressure/pass-through:
  - Channel 2 full with 0xAAAA0000 and out_ready=0: present in_sel=2 -> in_ready=0 and data holds.
  - Present in_sel=1 -> in_ready=1 and the word is accepted.
  - Raise out_ready[2] with in_sel=2, data 0xBBBB0000 -> one-cycle drain of 0xAAAA0000 and reload. out_valid[2] stays 1, out_data2=0xBBBB0000.
- Concurrent drain: all four channels full, out_ready=4'b1111, in_valid=0 -> after one edge out_valid=0 and busy=0.
- Flush: v=4'b0011, flush=1 with in_valid=1, in_sel=3 -> in_ready=0. Next edge out_valid=0, out_data0/1 unchanged, channel 3 not loaded.
- Streaming: in_sel=1 every cycle, out_ready[1]=1, data incrementing 0..15 -> consumer receives 0..15 in order with no bubbles and no loss. Then drop out_ready[1] for 3 cycles -> in_ready=0 and out_data1 stable for those 3 cycles.

Source files
------------

// File: rtl/demux4_hold.sv
// 4-way registered demultiplexer: one valid/ready input routed by in_sel into
// four independent single-entry holding registers, each drained by its own consumer.
module demux4_hold #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy
);

    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic             w_accept;
    logic [3:0]       w_load;

    // Ready depends only on the selected channel, so other blocked channels never stall the producer.
    assign in_ready = ~flush & (~r_valid[in_sel] | out_ready[in_sel]);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                end
                // Flush wins over reload; a reload in the same cycle as a drain keeps the channel full.
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign busy      = |r_valid;

endmodule

// File: tb/tb_demux4_hold.sv
// Self-checking bench for demux4_hold: directed vector table, hand sequences
// for reset/streaming/backpressure, and randomized traffic against a channel model.
module tb_demux4_hold;

    localparam int W = 32;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic        fl;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        int          chk_ch;
        logic [31:0] exp_d;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_sel = '0;
    logic [W-1:0] in_data = '0;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = '0;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic         busy;

    int checks = 0;
    int failures = 0;

    logic [3:0]   mv;
    logic [W-1:0] md [4];
    logic [W-1:0] rxq [$];

    demux4_hold #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] od(input int k);
        case (k)
            0: od = out_data0;
            1: od = out_data1;
            2: od = out_data2;
            default: od = out_data3;
        endcase
    endfunction

    task automatic model_clear();
        mv = '0;
        for (int k = 0; k < 4; k++) md[k] = '0;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] r, input logic f);
        in_valid = v; in_sel = s; in_data = d; out_ready = r; flush = f;
    endtask

    // One clock: check ready against the model, advance model by the channel rules, check outputs.
    task automatic step(input string tag);
        logic er, acc;
        logic [1:0] s;
        logic [W-1:0] d;
        logic [3:0] r;
        logic f;
        #1;
        s = in_sel; d = in_data; r = out_ready; f = flush;
        er = !f && (!mv[s] || r[s]);
        chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, er});
        acc = in_valid && er;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (acc && s == k) md[k] = d;
            if (f) mv[k] = 1'b0;
            else if (acc && s == k) mv[k] = 1'b1;
            else if (r[k]) mv[k] = 1'b0;
        end
        #1;
        chk({tag, " out_valid"}, {28'b0, out_valid}, {28'b0, mv});
        chk({tag, " busy"}, {31'b0, busy}, {31'b0, |mv});
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s out_data%0d", tag, k), od(k), md[k]);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1, 2'd0, 32'h11111111, 4'b0000, 0, 1, 4'b0001, 0, 32'h11111111};
        tbl[1]  = '{1, 2'd1, 32'h22222222, 4'b0000, 0, 1, 4'b0011, 1, 32'h22222222};
        tbl[2]  = '{1, 2'd2, 32'h33333333, 4'b0000, 0, 1, 4'b0111, 2, 32'h33333333};
        tbl[3]  = '{1, 2'd3, 32'h44444444, 4'b0000, 0, 1, 4'b1111, 3, 32'h44444444};
        tbl[4]  = '{1, 2'd2, 32'hAAAA0000, 4'b0000, 0, 0, 4'b1111, 2, 32'h33333333};
        tbl[5]  = '{1, 2'd2, 32'hAAAA0000, 4'b0100, 0, 1, 4'b1111, 2, 32'hAAAA0000};
        tbl[6]  = '{1, 2'd2, 32'hCCCC0000, 4'b0000, 0, 0, 4'b1111, 2, 32'hAAAA0000};
        tbl[7]  = '{1, 2'd1, 32'h55555555, 4'b0010, 0, 1, 4'b1111, 1, 32'h55555555};
        tbl[8]  = '{1, 2'd2, 32'hBBBB0000, 4'b0100, 0, 1, 4'b1111, 2, 32'hBBBB0000};
        tbl[9]  = '{0, 2'd0, 32'h0,        4'b1111, 0, 1, 4'b0000, 0, 32'h11111111};
        tbl[10] = '{1, 2'd0, 32'hD0D0D0D0, 4'b0000, 0, 1, 4'b0001, 0, 32'hD0D0D0D0};
        tbl[11] = '{1, 2'd1, 32'hD1D1D1D1, 4'b0000, 0, 1, 4'b0011, 1, 32'hD1D1D1D1};
        tbl[12] = '{1, 2'd3, 32'hEEEEEEEE, 4'b0000, 1, 0, 4'b0000, 3, 32'h44444444};

        // Reset state and mid-cycle asynchronous reset with channels 0 and 2 full.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        #1;
        chk("reset out_valid", {28'b0, out_valid}, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        drive(1, 0, 32'h0F0F0F0F, 0, 0); step("preload0");
        drive(1, 2, 32'hF0F0F0F0, 0, 0); step("preload2");
        drive(0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {28'b0, out_valid}, 32'h0);
        chk("async rst busy", {31'b0, busy}, 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("async rst out_data%0d", k), od(k), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1 chk($sformatf("idle in_ready sel%0d", s), {31'b0, in_ready}, 32'h1);
        end

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy, tbl[i].fl);
            #1 chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].exp_rdy});
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d table out_valid", i), {28'b0, out_valid}, {28'b0, tbl[i].exp_ov});
            chk($sformatf("vec%0d table data", i), od(tbl[i].chk_ch), tbl[i].exp_d);
        end
        chk("flush kept out_data0", out_data0, 32'hD0D0D0D0);
        chk("flush kept out_data1", out_data1, 32'hD1D1D1D1);

        // Streaming on channel 1 at full throughput.
        do_reset();
        rxq.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 32'(i), 4'b0010, 0);
            if (out_valid[1]) rxq.push_back(out_data1);
            #1 chk($sformatf("stream%0d in_ready", i), {31'b0, in_ready}, 32'h1);
            step($sformatf("stream%0d", i));
        end
        drive(0, 1, 0, 4'b0010, 0);
        if (out_valid[1]) rxq.push_back(out_data1);
        step("stream drain");
        chk("stream count", 32'(rxq.size()), 32'd16);
        for (int i = 0; i < 16 && i < rxq.size(); i++) begin
            chk($sformatf("stream word%0d", i), rxq[i], 32'(i));
        end

        // Backpressure on channel 1 for three cycles.
        drive(1, 1, 32'h77777777, 4'b0000, 0); step("bp load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h88888888, 4'b0000, 0);
            #1 chk($sformatf("bp%0d in_ready", i), {31'b0, in_ready}, 32'h0);
            step($sformatf("bp%0d", i));
            chk($sformatf("bp%0d out_data1", i), out_data1, 32'h77777777);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
            step($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
